// File: rtl/tt_response_checker.sv
// Truth-table sweep engine: applies every input vector to a combinational equation,
// samples its output after a settle interval and compares against an expected table.
module tt_response_checker #(
    parameter int                       N_IN      = 5,
    parameter int                       SETTLE    = 2,
    parameter logic [(2**N_IN)-1:0]     EXP_TABLE = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        z_in,
    output logic [N_IN-1:0]             x_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_IN:0]               err_count,
    output logic [N_IN-1:0]             first_err_idx,
    output logic [(2**N_IN)-1:0]        captured
);

    localparam int                NV        = 2**N_IN;
    localparam int                CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]     SETTLE_LD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
    localparam logic [N_IN-1:0]   LAST_IDX  = N_IN'(NV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    // With no settle time a vector is sampled in the same cycle it is applied.
    localparam state_t S_FIRST = (SETTLE == 0) ? S_SAMPLE : S_APPLY;

    state_t              r_state;
    logic [N_IN-1:0]     r_idx;
    logic [CW-1:0]       r_cnt;
    logic [N_IN-1:0]     r_x;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [N_IN:0]       r_err;
    logic [N_IN-1:0]     r_first;
    logic [NV-1:0]       r_cap;

    logic                w_mismatch;
    logic                w_last;

    // Case inequality so an undriven or unknown z_in is scored as a failure.
    assign w_mismatch = (z_in !== EXP_TABLE[r_idx]);
    assign w_last     = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
            r_cap   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_x    <= '0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_state <= S_FIRST;
                        r_idx   <= '0;
                        r_cnt   <= SETTLE_LD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_first <= '0;
                        r_cap   <= '0;
                    end
                end
                S_APPLY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_cap[r_idx] <= z_in;
                    if (w_mismatch) begin
                        r_err <= r_err + 1'b1;
                        if (r_err == '0) begin
                            r_first <= r_idx;
                        end
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_x     <= r_idx + 1'b1;
                        r_cnt   <= SETTLE_LD;
                        r_state <= S_FIRST;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == '0);
                    r_x     <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x_out         = r_x;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign first_err_idx = r_first;
    assign captured      = r_cap;

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: three parameterisations driven by truth-table
// functions, scored against a popcount/lowest-bit model of the expected table.
module tb_tt_response_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a [3];
    logic        z_a     [3];
    logic [4:0]  x_a     [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic        pass_a  [3];
    logic [5:0]  err_a   [3];
    logic [4:0]  fe_a    [3];
    logic [31:0] cap_a   [3];
    logic [31:0] func_a  [3];

    logic [31:0] exp_tab  [3] = '{32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_FFFF};
    int          settle_a [3] = '{2, 2, 0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            z_a[i] = func_a[i][x_a[i]];
        end
    end

    tt_response_checker u_def (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .z_in(z_a[0]),
        .x_out(x_a[0]), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
        .err_count(err_a[0]), .first_err_idx(fe_a[0]), .captured(cap_a[0])
    );

    tt_response_checker #(.N_IN(5), .SETTLE(2), .EXP_TABLE(32'hFFFF_0000)) u_x1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .z_in(z_a[1]),
        .x_out(x_a[1]), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
        .err_count(err_a[1]), .first_err_idx(fe_a[1]), .captured(cap_a[1])
    );

    tt_response_checker #(.N_IN(5), .SETTLE(0), .EXP_TABLE(32'hFFFF_FFFF)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .z_in(z_a[2]),
        .x_out(x_a[2]), .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]),
        .err_count(err_a[2]), .first_err_idx(fe_a[2]), .captured(cap_a[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full sweep on instance k; optionally pulses start once when x_out reaches pulse_at.
    task automatic sweep(input int k, input int pulse_at);
        int          cyc;
        int          xbad;
        int          s;
        int          n_err;
        int          first;
        bit          pulsed;
        logic [31:0] mm;
        s      = settle_a[k];
        pulsed = 1'b0;
        @(negedge clk) start_a[k] = 1'b1;
        @(negedge clk) start_a[k] = 1'b0;
        check($sformatf("i%0d_start_clear", k), {done_a[k], pass_a[k], err_a[k], fe_a[k], cap_a[k]}, 64'd0);
        cyc  = 0;
        xbad = 0;
        while (busy_a[k] && cyc < 400) begin
            cyc++;
            if (cyc <= 32 * (s + 1) && x_a[k] !== 5'((cyc - 1) / (s + 1))) xbad++;
            if (pulse_at >= 0 && !pulsed && int'(x_a[k]) == pulse_at) begin
                start_a[k] = 1'b1;
                pulsed     = 1'b1;
            end else begin
                start_a[k] = 1'b0;
            end
            @(negedge clk);
        end
        start_a[k] = 1'b0;
        check($sformatf("i%0d_busy_cycles", k), 64'(cyc), 64'(32 * (s + 1) + 1));
        check($sformatf("i%0d_x_sequence", k), 64'(xbad), 64'd0);

        mm    = func_a[k] ^ exp_tab[k];
        n_err = $countones(mm);
        first = 0;
        for (int i = 31; i >= 0; i--) if (mm[i]) first = i;

        check($sformatf("i%0d_done", k), 64'(done_a[k]), 64'd1);
        check($sformatf("i%0d_pass", k), 64'(pass_a[k]), 64'(n_err == 0));
        check($sformatf("i%0d_err_count", k), 64'(err_a[k]), 64'(n_err));
        check($sformatf("i%0d_first_err", k), 64'(fe_a[k]), 64'(first));
        check($sformatf("i%0d_captured", k), 64'(cap_a[k]), 64'(func_a[k]));
        check($sformatf("i%0d_x_idle", k), 64'(x_a[k]), 64'd0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            func_a[i]  = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d_reset_state", i),
                  {x_a[i], busy_a[i], done_a[i], pass_a[i], err_a[i], fe_a[i], cap_a[i]}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero equation against all-zero table
        func_a[0] = 32'h0;
        sweep(0, -1);

        // z = x1, then single and double faults; the double-fault sweep is repeated
        func_a[1] = 32'hFFFF_0000;
        sweep(1, -1);
        func_a[1] = 32'hFFFF_0008;
        sweep(1, -1);
        check("x1_one_err_count", 64'(err_a[1]), 64'd1);
        func_a[1] = 32'hBFFF_0008;
        sweep(1, -1);
        check("x1_two_err_first", 64'(fe_a[1]), 64'd3);
        sweep(1, -1);

        // Reset mid-sweep at vector 10
        func_a[0] = 32'h1234_5678;
        @(negedge clk) start_a[0] = 1'b1;
        @(negedge clk) start_a[0] = 1'b0;
        w = 0;
        while (x_a[0] != 5'd10 && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("reach_x10", 64'(w < 200), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midsweep_reset_outputs",
              {x_a[0], busy_a[0], done_a[0], pass_a[0], err_a[0], fe_a[0], cap_a[0]}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_done", 64'(done_a[0]), 64'd0);

        // Fresh sweep with an ignored start at vector 20
        sweep(0, 20);

        // Zero-settle instance
        func_a[2] = 32'hFFFF_FFFF;
        sweep(2, -1);

        // Randomized equations
        for (int n = 0; n < 8; n++) begin
            int k;
            int mode;
            k    = (n % 2 == 0) ? 1 : 2;
            mode = $urandom_range(0, 2);
            case (mode)
                0:       func_a[k] = $urandom;
                1:       func_a[k] = exp_tab[k] ^ (32'h1 << $urandom_range(0, 31));
                default: func_a[k] = exp_tab[k];
            endcase
            sweep(k, (n % 3 == 0) ? int'($urandom_range(0, 31)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
